// File: rtl/dram_arbiter_if.sv
// One master's request/response bundle toward the data-RAM arbiter.
// The master holds req (with we/lock/addr/wdata) until gnt; read data returns on rvalid/rdata.
interface dram_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) ();
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter of two masters onto the single-port data RAM, with a bounded lock for RMW.
// Grant is combinational in the request cycle, read data one cycle later; losers hold req until gnt.
module dram_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    dram_arbiter_if.slave     m0,
    dram_arbiter_if.slave     m1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             rvalid0Q;
    logic             rvalid1Q;
    logic             gnt0;
    logic             gnt1;
    logic             atMax;

    assign atMax = (cnt == CNT_W'(LOCK_MAX));

    // last holds the previous winner's index, so a tie goes to the other master.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (m0.req && m1.req) begin
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = m0.req;
                        gnt1 = m1.req;
                    end
                end
                LOCK0: begin
                    if (atMax && m1.req) gnt1 = 1'b1;
                    else                 gnt0 = m0.req;
                end
                LOCK1: begin
                    if (atMax && m0.req) gnt0 = 1'b1;
                    else                 gnt1 = m1.req;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
        end else begin
            rvalid0Q <= gnt0 && !m0.we;
            rvalid1Q <= gnt1 && !m1.we;
            if (gnt0) last <= 1'b0;
            if (gnt1) last <= 1'b1;
            case (state)
                IDLE: begin
                    if (gnt0 && m0.lock) begin
                        state <= LOCK0;
                        cnt   <= CNT_W'(1);
                    end else if (gnt1 && m1.lock) begin
                        state <= LOCK1;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                LOCK0: begin
                    // Tenure ends on lock drop, or when the bound is hit and the other master waits.
                    if ((atMax && m1.req) || !m0.lock) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (gnt0 && !atMax) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCK1: begin
                    if ((atMax && m0.req) || !m1.lock) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (gnt1 && !atMax) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt0) begin
            ram_we   = m0.we;
            ram_addr = m0.addr;
            ram_din  = m0.wdata;
        end else if (gnt1) begin
            ram_we   = m1.we;
            ram_addr = m1.addr;
            ram_din  = m1.wdata;
        end
    end

    // Gating with rst squashes a read still in flight when reset arrives.
    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid0Q && !rst;
    assign m1.rvalid = rvalid1Q && !rst;
    assign m0.rdata  = ram_dout;
    assign m1.rdata  = ram_dout;
endmodule
